// File: rtl/pd_debug_pkg.sv
// Shared types and constants for the PD debug capture master: FSM states,
// RAM map of the debug RAM and the bit layout of the status header word.
package pd_debug_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WR_DATA,
        ST_WR_HDR,
        ST_WR_FRZ
    } state_t;

    localparam int HDR_ADDR   = 0;
    localparam int RING_FIRST = 1;
    localparam int RING_LAST  = 15;

    localparam logic [1:0] HDR_VERSION = 2'b01;

    localparam int HDR_EVT_LSB  = 16;
    localparam int HDR_DROP_LSB = 8;
    localparam int HDR_PTR_LSB  = 4;
    localparam int HDR_WRAP_BIT = 3;
    localparam int HDR_FRZ_BIT  = 2;
    localparam int HDR_VER_LSB  = 0;

    function automatic logic [31:0] make_header(
        input logic [15:0] evt,
        input logic [7:0]  drop,
        input logic [3:0]  ptr,
        input logic        wrapped,
        input logic        frz
    );
        logic [31:0] h;
        h = '0;
        h[HDR_EVT_LSB  +: 16] = evt;
        h[HDR_DROP_LSB +: 8]  = drop;
        h[HDR_PTR_LSB  +: 4]  = ptr;
        h[HDR_WRAP_BIT]       = wrapped;
        h[HDR_FRZ_BIT]        = frz;
        h[HDR_VER_LSB  +: 2]  = HDR_VERSION;
        return h;
    endfunction

endpackage

// File: rtl/pd_debug_evt_fifo.sv
// Small synchronous event FIFO with first-word-fall-through output.
// The caller never pushes when full without popping, nor pops when empty.
module pd_debug_evt_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pd_debug_capture_master.sv
// Avalon-MM write master that logs debug events into the 16x32 PD debug RAM:
// word 0 is a status header, words 1..15 a circular event log.
module pd_debug_capture_master
    import pd_debug_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              evt_valid,
    input  logic [DATA_W-1:0] evt_data,
    input  logic              freeze,
    input  logic              clear_req,
    output logic              chipselect,
    output logic              write,
    output logic [ADDR_W-1:0] address,
    output logic [3:0]        byteenable,
    output logic [DATA_W-1:0] writedata,
    output logic              overflow,
    output logic              busy
);

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] sweep_q, sweep_n;
    logic [ADDR_W-1:0] wr_ptr_q, ptr_adv;
    logic              wrapped_q, wrap_adv;
    logic [15:0]       evt_cnt_q, evt_inc;
    logic [7:0]        drop_cnt_q, drop_cnt_n;
    logic              clear_pend_q, frz_pend_q, freeze_q;
    logic              rise, enter_clear, enter_frz, pop, push, drop;
    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic              wr_n, hdr_adv;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] data_n;

    // evt_valid has no ready: an event meeting a full FIFO with no pop that
    // cycle is dropped and counted; a pop in the same cycle frees the slot.
    assign rise        = freeze && !freeze_q;
    assign enter_clear = (state_q == ST_IDLE) && clear_pend_q;
    assign enter_frz   = (state_q == ST_IDLE) && !clear_pend_q && frz_pend_q;
    assign pop         = (state_q == ST_IDLE) && !clear_pend_q && !frz_pend_q
                         && !fifo_empty && !freeze;
    assign push        = evt_valid && (!fifo_full || pop) && !enter_clear;
    assign drop        = evt_valid && fifo_full && !pop && !enter_clear;

    assign drop_cnt_n = enter_clear ? 8'h00 :
                        (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    assign evt_inc    = (evt_cnt_q == 16'hFFFF) ? evt_cnt_q : evt_cnt_q + 16'd1;
    assign ptr_adv    = (wr_ptr_q == ADDR_W'(RING_LAST)) ? ADDR_W'(RING_FIRST)
                                                         : wr_ptr_q + 1'b1;
    assign wrap_adv   = wrapped_q || (wr_ptr_q == ADDR_W'(RING_LAST));
    assign busy       = (state_q != ST_IDLE);

    pd_debug_evt_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (enter_clear),
        .din   (evt_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    // Bus outputs are computed for the next state so each write is on the
    // bus during the cycle its state is current.
    always_comb begin
        state_n = state_q;
        sweep_n = sweep_q;
        wr_n    = 1'b0;
        hdr_adv = 1'b0;
        addr_n  = '0;
        data_n  = '0;
        case (state_q)
            ST_IDLE: begin
                if (enter_clear) begin
                    state_n = ST_CLEAR;
                    sweep_n = '0;
                    wr_n    = 1'b1;
                    addr_n  = ADDR_W'(HDR_ADDR);
                end else if (enter_frz) begin
                    state_n = ST_WR_FRZ;
                    wr_n    = 1'b1;
                    addr_n  = ADDR_W'(HDR_ADDR);
                    data_n  = DATA_W'(make_header(evt_cnt_q, drop_cnt_n, wr_ptr_q, wrapped_q, 1'b1));
                end else if (pop) begin
                    state_n = ST_WR_DATA;
                    wr_n    = 1'b1;
                    addr_n  = wr_ptr_q;
                    data_n  = fifo_dout;
                end
            end
            ST_CLEAR: begin
                if (sweep_q == ADDR_W'(RING_LAST)) begin
                    state_n = ST_IDLE;
                end else begin
                    sweep_n = sweep_q + 1'b1;
                    wr_n    = 1'b1;
                    addr_n  = sweep_q + 1'b1;
                end
            end
            ST_WR_DATA: begin
                state_n = ST_WR_HDR;
                hdr_adv = 1'b1;
                wr_n    = 1'b1;
                addr_n  = ADDR_W'(HDR_ADDR);
                data_n  = DATA_W'(make_header(evt_inc, drop_cnt_n, ptr_adv, wrap_adv, freeze));
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sweep_q      <= '0;
            clear_pend_q <= 1'b1;
            frz_pend_q   <= 1'b0;
            freeze_q     <= 1'b0;
            wr_ptr_q     <= ADDR_W'(RING_FIRST);
            wrapped_q    <= 1'b0;
            evt_cnt_q    <= '0;
            drop_cnt_q   <= '0;
            chipselect   <= 1'b0;
            write        <= 1'b0;
            address      <= '0;
            byteenable   <= 4'h0;
            writedata    <= '0;
            overflow     <= 1'b0;
        end else begin
            state_q    <= state_n;
            sweep_q    <= sweep_n;
            freeze_q   <= freeze;
            drop_cnt_q <= drop_cnt_n;
            if (enter_clear)
                clear_pend_q <= 1'b0;
            else if (clear_req && state_q != ST_CLEAR)
                clear_pend_q <= 1'b1;
            if (enter_clear)    frz_pend_q <= 1'b0;
            else if (rise)      frz_pend_q <= 1'b1;
            else if (enter_frz) frz_pend_q <= 1'b0;
            if (enter_clear) begin
                wr_ptr_q  <= ADDR_W'(RING_FIRST);
                wrapped_q <= 1'b0;
                evt_cnt_q <= '0;
            end else if (hdr_adv) begin
                wr_ptr_q  <= ptr_adv;
                wrapped_q <= wrap_adv;
                evt_cnt_q <= evt_inc;
            end
            chipselect <= wr_n;
            write      <= wr_n;
            address    <= addr_n;
            byteenable <= wr_n ? 4'hF : 4'h0;
            writedata  <= data_n;
            overflow   <= drop;
        end
    end

endmodule

// File: tb/tb_pd_debug_capture_master.sv
// Self-checking bench for pd_debug_capture_master: a queue-based reference
// model predicts the RAM write log, which is compared against the bus log.
module tb_pd_debug_capture_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        evt_valid = 1'b0;
    logic [31:0] evt_data = '0;
    logic        freeze = 1'b0;
    logic        clear_req = 1'b0;
    logic        chipselect, write, overflow, busy;
    logic [3:0]  address, byteenable;
    logic [31:0] writedata;

    int n_cmp = 0;
    int n_fail = 0;
    logic [35:0] exp_q[$];
    logic [35:0] obs_q[$];
    int obs_ovf = 0;
    int exp_ovf = 0;
    int bus_err = 0;

    pd_debug_capture_master dut (
        .clk        (clk),
        .reset      (reset),
        .evt_valid  (evt_valid),
        .evt_data   (evt_data),
        .freeze     (freeze),
        .clear_req  (clear_req),
        .chipselect (chipselect),
        .write      (write),
        .address    (address),
        .byteenable (byteenable),
        .writedata  (writedata),
        .overflow   (overflow),
        .busy       (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    localparam int K_NONE = 0, K_ZERO = 1, K_DATA = 2, K_HDR = 3, K_FRZ = 4;
    typedef struct {
        int          kind;
        logic [3:0]  addr;
        logic [31:0] data;
    } item_t;

    item_t       m_sched[$];
    logic [31:0] m_evq[$];
    logic        m_clear_pend = 1'b1;
    logic        m_frz_pend = 1'b0;
    logic        m_freeze_q = 1'b0;
    logic        m_wrapped = 1'b0;
    int          m_evt = 0;
    int          m_drop = 0;
    int          m_ptr = 1;
    int          m_cur = K_NONE;

    function automatic logic [31:0] ref_header(input int evt, input int drop, input int ptr,
                                               input logic wr, input logic frz);
        longint v;
        v = longint'(evt) * 65536 + drop * 256 + ptr * 16 + (wr ? 8 : 0) + (frz ? 4 : 0) + 1;
        return v[31:0];
    endfunction

    always @(posedge clk) begin : ref_model
        item_t it;
        logic  was_clear, rise, ent_clear, ent_frz, did_pop, full;
        if (reset) begin
            m_sched.delete();
            m_evq.delete();
            m_clear_pend = 1'b1;
            m_frz_pend   = 1'b0;
            m_freeze_q   = 1'b0;
            m_wrapped    = 1'b0;
            m_evt        = 0;
            m_drop       = 0;
            m_ptr        = 1;
            m_cur        = K_NONE;
        end else begin
            was_clear  = (m_cur == K_ZERO);
            rise       = freeze && !m_freeze_q;
            m_freeze_q = freeze;
            ent_clear  = 1'b0;
            ent_frz    = 1'b0;
            did_pop    = 1'b0;
            full       = (m_evq.size() == 4);
            if (m_sched.size() == 0) begin
                if (m_clear_pend) begin
                    ent_clear = 1'b1;
                    for (int k = 0; k < 16; k++) m_sched.push_back('{K_ZERO, 4'(k), 32'h0});
                    m_sched.push_back('{K_NONE, 4'h0, 32'h0});
                end else if (m_frz_pend) begin
                    ent_frz = 1'b1;
                    m_sched.push_back('{K_FRZ, 4'h0, 32'h0});
                    m_sched.push_back('{K_NONE, 4'h0, 32'h0});
                end else if (m_evq.size() > 0 && !freeze) begin
                    did_pop = 1'b1;
                    m_sched.push_back('{K_DATA, 4'(m_ptr), m_evq.pop_front()});
                    m_sched.push_back('{K_HDR, 4'h0, 32'h0});
                    m_sched.push_back('{K_NONE, 4'h0, 32'h0});
                end
            end
            if (ent_clear) begin
                m_evq.delete();
                m_evt = 0;
                m_drop = 0;
                m_ptr = 1;
                m_wrapped = 1'b0;
            end else if (evt_valid) begin
                if (!full || did_pop) m_evq.push_back(evt_data);
                else begin
                    if (m_drop < 255) m_drop++;
                    exp_ovf++;
                end
            end
            if (ent_clear) m_clear_pend = 1'b0;
            else if (clear_req && !was_clear) m_clear_pend = 1'b1;
            if (ent_clear) m_frz_pend = 1'b0;
            else if (rise) m_frz_pend = 1'b1;
            else if (ent_frz) m_frz_pend = 1'b0;
            if (m_sched.size() != 0) begin
                it = m_sched.pop_front();
                m_cur = it.kind;
                case (it.kind)
                    K_ZERO, K_DATA: exp_q.push_back({it.addr, it.data});
                    K_HDR: begin
                        if (m_evt < 65535) m_evt++;
                        if (m_ptr == 15) begin
                            m_ptr = 1;
                            m_wrapped = 1'b1;
                        end else m_ptr++;
                        exp_q.push_back({4'h0, ref_header(m_evt, m_drop, m_ptr, m_wrapped, freeze)});
                    end
                    K_FRZ: exp_q.push_back({4'h0, ref_header(m_evt, m_drop, m_ptr, m_wrapped, 1'b1)});
                    default: ;
                endcase
            end else m_cur = K_NONE;
        end
    end

    // ---------------- bus monitor ----------------
    always @(negedge clk) begin
        if (write === 1'b1) obs_q.push_back({address, writedata});
        if (overflow === 1'b1) obs_ovf++;
        if (!reset && (busy !== write || chipselect !== write ||
                       byteenable !== (write ? 4'hF : 4'h0))) bus_err++;
    end

    function automatic logic [35:0] obs_at(input int i);
        if (i >= 0 && i < obs_q.size()) return obs_q[i];
        return 36'hx;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [31:0] d, input logic clr);
        evt_valid = v;
        evt_data  = d;
        clear_req = clr;
        @(negedge clk);
        evt_valid = 1'b0;
        clear_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_logs();
        obs_q.delete();
        exp_q.delete();
        obs_ovf = 0;
        exp_ovf = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle(3);
        n_cmp++;
        if ({chipselect, write, address, byteenable, writedata, overflow, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got cs=%b wr=%b a=%h be=%h d=%h ovf=%b busy=%b want all 0",
                     chipselect, write, address, byteenable, writedata, overflow, busy);
        end
        reset_logs();
        reset = 1'b0;
        idle(25);
        n_cmp++;
        if (obs_q.size() != 16) begin
            n_fail++;
            $display("FAIL sweep_len: got %0d want 16", obs_q.size());
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (obs_at(i) !== {4'(i), 32'h0}) begin
                n_fail++;
                $display("FAIL sweep_wr[%0d]: got %h want %h", i, obs_at(i), {4'(i), 32'h0});
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_busy_done: got %b want 0", busy);
        end
    endtask

    task automatic test_single_event();
        reset_logs();
        drive(1'b1, 32'hDEADBEEF, 1'b0);
        idle(8);
        n_cmp++;
        if (obs_at(0) !== {4'h1, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL single_data: got %h want %h", obs_at(0), {4'h1, 32'hDEADBEEF});
        end
        n_cmp++;
        if (obs_at(1) !== {4'h0, 32'h00010021}) begin
            n_fail++;
            $display("FAIL single_hdr: got %h want %h", obs_at(1), {4'h0, 32'h00010021});
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL single_len: got %0d want %0d", obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 32'h0, 1'b1);
        idle(22);
        reset_logs();
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, $urandom, 1'b0);
            idle(3);
        end
        idle(6);
        n_cmp++;
        if (obs_at(obs_q.size() - 1) !== {4'h0, 32'h000F0019}) begin
            n_fail++;
            $display("FAIL wrap_hdr: got %h want %h", obs_at(obs_q.size() - 1), {4'h0, 32'h000F0019});
        end
        drive(1'b1, 32'hA5A5_0016, 1'b0);
        idle(6);
        n_cmp++;
        if (obs_at(obs_q.size() - 2) !== {4'h1, 32'hA5A5_0016}) begin
            n_fail++;
            $display("FAIL wrap_16th: got %h want %h", obs_at(obs_q.size() - 2), {4'h1, 32'hA5A5_0016});
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL wrap_len: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_at(i) !== exp_q[i]) begin
                n_fail++;
                $display("FAIL wrap_wr[%0d]: got %h want %h", i, obs_at(i), exp_q[i]);
            end
        end
    endtask

    task automatic test_freeze();
        logic [31:0] d[6];
        drive(1'b0, 32'h0, 1'b1);
        idle(22);
        reset_logs();
        freeze = 1'b1;
        idle(4);
        for (int i = 0; i < 6; i++) begin
            d[i] = $urandom;
            drive(1'b1, d[i], 1'b0);
        end
        idle(4);
        n_cmp++;
        if (obs_q.size() != 1 || obs_at(0) !== {4'h0, 32'h00000015}) begin
            n_fail++;
            $display("FAIL frz_hdr: got n=%0d %h want n=1 %h", obs_q.size(), obs_at(0), {4'h0, 32'h00000015});
        end
        n_cmp++;
        if (obs_ovf != 2) begin
            n_fail++;
            $display("FAIL frz_overflow: got %0d want 2", obs_ovf);
        end
        freeze = 1'b0;
        idle(20);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (obs_at(1 + 2 * k) !== {4'(k + 1), d[k]}) begin
                n_fail++;
                $display("FAIL frz_drain[%0d]: got %h want %h", k, obs_at(1 + 2 * k), {4'(k + 1), d[k]});
            end
        end
        n_cmp++;
        if (obs_q.size() != 9 || obs_at(8) !== {4'h0, 32'h00040251}) begin
            n_fail++;
            $display("FAIL frz_final_hdr: got n=%0d %h want n=9 %h", obs_q.size(), obs_at(8), {4'h0, 32'h00040251});
        end
    endtask

    task automatic test_drop_saturate();
        drive(1'b0, 32'h0, 1'b1);
        idle(22);
        reset_logs();
        freeze = 1'b1;
        idle(4);
        for (int i = 0; i < 270; i++) drive(1'b1, $urandom, 1'b0);
        freeze = 1'b0;
        idle(20);
        n_cmp++;
        if (obs_at(obs_q.size() - 1) !== {4'h0, 32'h0004FF51}) begin
            n_fail++;
            $display("FAIL sat_hdr: got %h want %h", obs_at(obs_q.size() - 1), {4'h0, 32'h0004FF51});
        end
        n_cmp++;
        if (obs_ovf != 266) begin
            n_fail++;
            $display("FAIL sat_overflow: got %0d want 266", obs_ovf);
        end
    endtask

    task automatic test_clear_mid_write();
        reset_logs();
        drive(1'b1, 32'h1234_5678, 1'b0);
        drive(1'b0, 32'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b1);
        idle(25);
        drive(1'b1, 32'hCAFE_F00D, 1'b0);
        idle(8);
        n_cmp++;
        if (obs_q.size() != 20) begin
            n_fail++;
            $display("FAIL clrmid_len: got %0d want 20", obs_q.size());
        end
        n_cmp++;
        if (obs_at(1) === 36'h0 || obs_at(1) !== exp_q[1]) begin
            n_fail++;
            $display("FAIL clrmid_hdr: got %h want %h", obs_at(1), exp_q[1]);
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (obs_at(2 + i) !== {4'(i), 32'h0}) begin
                n_fail++;
                $display("FAIL clrmid_sweep[%0d]: got %h want %h", i, obs_at(2 + i), {4'(i), 32'h0});
            end
        end
        n_cmp++;
        if (obs_at(18) !== {4'h1, 32'hCAFE_F00D} || obs_at(19) !== {4'h0, 32'h00010021}) begin
            n_fail++;
            $display("FAIL clrmid_after: got %h %h want %h %h", obs_at(18), obs_at(19),
                     {4'h1, 32'hCAFE_F00D}, {4'h0, 32'h00010021});
        end
    endtask

    task automatic test_random();
        reset_logs();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 60) == 0) freeze = ~freeze;
            drive($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 150) == 0);
        end
        freeze = 1'b0;
        idle(60);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_len: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_at(i) !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_wr[%0d]: got %h want %h", i, obs_at(i), exp_q[i]);
            end
        end
        n_cmp++;
        if (obs_ovf != exp_ovf) begin
            n_fail++;
            $display("FAIL rand_overflow: got %0d want %0d", obs_ovf, exp_ovf);
        end
        n_cmp++;
        if (bus_err != 0) begin
            n_fail++;
            $display("FAIL bus_protocol: got %0d bad cycles want 0", bus_err);
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic found;
        reset_logs();
        drive(1'b0, 32'h0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (write === 1'b1 && address === 4'd7) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL rstmid_reach7: got no write to 7 want one within 40 cycles");
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({chipselect, write, address, byteenable, writedata, overflow, busy} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got cs=%b wr=%b a=%h be=%h d=%h want all 0",
                     chipselect, write, address, byteenable, writedata);
        end
        reset = 1'b0;
        idle(25);
        n_cmp++;
        if (obs_q.size() != 24 || obs_at(8) !== 36'h0 || obs_at(23) !== {4'hF, 32'h0}) begin
            n_fail++;
            $display("FAIL rstmid_restart: got n=%0d %h %h want n=24 %h %h", obs_q.size(),
                     obs_at(8), obs_at(23), 36'h0, {4'hF, 32'h0});
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_at(i) !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rstmid_wr[%0d]: got %h want %h", i, obs_at(i), exp_q[i]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_event();
        test_wrap();
        test_freeze();
        test_drop_saturate();
        test_clear_mid_write();
        test_random();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
